// File: rtl/run_sequencer.sv
// Run controller: accepts a host run request, loads the core PC from a program
// slot table and supervises execution until halt, timeout or host abort.
module run_sequencer #(
    parameter int                  D           = 12,
    parameter int                  N_PROG      = 4,
    parameter logic [N_PROG*D-1:0] START_TABLE = {12'hC00, 12'h800, 12'h400, 12'h000},
    parameter int                  CW          = 16,
    parameter int                  TIMEOUT     = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [3:0]    prog_sel,
    input  logic          halt_in,
    output logic          pc_load,
    output logic [D-1:0]  pc_init,
    output logic          core_run,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          aborted,
    output logic [CW-1:0] cycle_count,
    output logic [7:0]    run_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

    state_t          state_q;
    logic            pc_load_q;
    logic [D-1:0]    pc_init_q;
    logic            core_run_q;
    logic            busy_q;
    logic            done_q;
    logic            timeout_q;
    logic            aborted_q;
    logic [CW-1:0]   cycle_q;
    logic [CW-1:0]   cycle_d;
    logic [7:0]      runs_q;
    logic [D-1:0]    sel_pc;

    // Out-of-range slot indices fall back to slot 0.
    always_comb begin
        sel_pc = START_TABLE[D-1:0];
        for (int unsigned i = 0; i < N_PROG; i++) begin
            if (prog_sel == 4'(i)) begin
                sel_pc = START_TABLE[i*D +: D];
            end
        end
    end

    assign cycle_d = cycle_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_load_q  <= 1'b0;
            pc_init_q  <= '0;
            core_run_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            aborted_q  <= 1'b0;
            cycle_q    <= '0;
            runs_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q   <= LOAD;
                        pc_load_q <= 1'b1;
                        pc_init_q <= sel_pc;
                        busy_q    <= 1'b1;
                        cycle_q   <= '0;
                        timeout_q <= 1'b0;
                        aborted_q <= 1'b0;
                    end
                end
                LOAD: begin
                    pc_load_q <= 1'b0;
                    pc_init_q <= '0;
                    if (req) begin
                        state_q    <= RUN;
                        core_run_q <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end
                end
                RUN: begin
                    cycle_q <= cycle_d;
                    // Host abort outranks halt, which outranks timeout.
                    if (!req) begin
                        state_q    <= IDLE;
                        core_run_q <= 1'b0;
                        busy_q     <= 1'b0;
                        aborted_q  <= 1'b1;
                    end else if (halt_in || (TO_EN && cycle_q == TO_LAST)) begin
                        state_q    <= DONE;
                        core_run_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        timeout_q  <= !halt_in;
                        runs_q     <= runs_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!req) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_load     = pc_load_q;
    assign pc_init     = pc_init_q;
    assign core_run    = core_run_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign aborted     = aborted_q;
    assign cycle_count = cycle_q;
    assign run_count   = runs_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: a driver issues runs and queues the
// expected outcome from a transaction-level model; a monitor checks them.
module tb_run_sequencer;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  prog_sel = '0;
    logic        halt_in = 1'b0;
    logic        pc_load;
    logic [11:0] pc_init;
    logic        core_run;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        aborted;
    logic [15:0] cycle_count;
    logic [7:0]  run_count;

    run_sequencer #(
        .D           (12),
        .N_PROG      (4),
        .START_TABLE ({12'hC00, 12'h800, 12'h400, 12'h000}),
        .CW          (16),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .prog_sel    (prog_sel),
        .halt_in     (halt_in),
        .pc_load     (pc_load),
        .pc_init     (pc_init),
        .core_run    (core_run),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .aborted     (aborted),
        .cycle_count (cycle_count),
        .run_count   (run_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fin;
        logic        to;
        logic        ab;
        logic [15:0] cyc;
        logic [7:0]  runs;
    } res_t;

    logic [11:0] pc_q[$];
    res_t        res_q[$];
    int          len_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          model_runs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [11:0] exp_pc(input int sel);
        logic [11:0] tbl[4];
        tbl = '{12'h000, 12'h400, 12'h800, 12'hC00};
        return (sel < 4) ? tbl[sel] : tbl[0];
    endfunction

    // halt_k / abort_k: RUN cycle (1-based) of the event, abort_k==0 means during LOAD,
    // values beyond the timeout never happen. hold: extra DONE cycles with req high.
    task automatic run_txn(input int sel, input int halt_k, input int abort_k, input int hold);
        res_t r;
        int   e;
        pc_q.push_back(exp_pc(sel));
        e = 0;
        r.fin = 1'b0; r.to = 1'b0; r.ab = 1'b0; r.cyc = '0;
        if (abort_k == 0) begin
            r.ab = 1'b1;
        end else begin
            e = TO;
            if (halt_k < e) e = halt_k;
            if (abort_k < e) e = abort_k;
            r.cyc = 16'(e);
            if (abort_k == e) r.ab = 1'b1;
            else begin
                r.fin = 1'b1;
                r.to  = (halt_k != e);
                model_runs = (model_runs + 1) % 256;
            end
        end
        r.runs = 8'(model_runs);
        res_q.push_back(r);
        if (r.fin) len_q.push_back(hold + 1);

        @(posedge clk); #1;
        req = 1'b1; prog_sel = 4'(sel);
        @(posedge clk); #1;
        prog_sel = 4'($urandom_range(0, 15));
        if (abort_k == 0) req = 1'b0;
        @(posedge clk); #1;
        if (abort_k != 0) begin
            for (int k = 1; k <= e; k++) begin
                halt_in = (k == halt_k);
                if (k == abort_k) req = 1'b0;
                @(posedge clk); #1;
                halt_in = 1'b0;
            end
        end
        if (r.fin) begin
            repeat (hold) begin @(posedge clk); #1; end
            req = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Monitor: checks PC loads, run outcomes at the busy fall, and DONE duration.
    initial begin
        logic busy_prev, done_prev;
        int   done_len;
        busy_prev = 1'b0; done_prev = 1'b0; done_len = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_prev = 1'b0; done_prev = 1'b0; done_len = 0;
            end else begin
                if (pc_load) begin
                    if (pc_q.size() == 0) check("pc_load_unexpected", 32'(pc_load), 32'd0);
                    else check("pc_init", 32'(pc_init), 32'(pc_q.pop_front()));
                end
                if (busy_prev && !busy) begin
                    if (res_q.size() == 0) check("run_end_unexpected", 32'(busy_prev), 32'd0);
                    else begin
                        res_t r;
                        r = res_q.pop_front();
                        check("done", 32'(done), 32'(r.fin));
                        check("timeout", 32'(timeout), 32'(r.to));
                        check("aborted", 32'(aborted), 32'(r.ab));
                        check("cycle_count", 32'(cycle_count), 32'(r.cyc));
                        check("run_count", 32'(run_count), 32'(r.runs));
                        check("core_run_off", 32'(core_run), 32'd0);
                    end
                end
                if (done) done_len++;
                if (done_prev && !done) begin
                    if (len_q.size() == 0) check("done_fall_unexpected", 32'(done_prev), 32'd0);
                    else check("done_length", 32'(done_len), 32'(len_q.pop_front()));
                    done_len = 0;
                end
                busy_prev = busy; done_prev = done;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel, hk, ak, hd;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_pc_init", 32'(pc_init), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cycle_count", 32'(cycle_count), 32'd0);
        check("rst_run_count", 32'(run_count), 32'd0);
        reset = 1'b1;

        run_txn(0, 5, 99, 0);    // basic run
        run_txn(2, 99, 99, 4);   // timeout, req held through DONE
        run_txn(7, 3, 99, 1);    // out-of-range slot
        run_txn(1, 20, 99, 0);   // halt on the timeout cycle
        run_txn(3, 99, 3, 0);    // abort in RUN
        run_txn(0, 99, 0, 0);    // abort in LOAD
        run_txn(1, 4, 4, 0);     // abort beats halt
        run_txn(2, 99, 20, 0);   // abort beats timeout
        run_txn(3, 1, 99, 2);    // halt on first RUN cycle

        for (int n = 0; n < 50; n++) begin
            sel = $urandom_range(0, 9);
            hk  = ($urandom_range(0, 1) == 0) ? 99 : $urandom_range(1, 22);
            ak  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 22) : 99;
            hd  = $urandom_range(0, 4);
            run_txn(sel, hk, ak, hd);
        end

        // Reset during RUN
        @(posedge clk); #1;
        req = 1'b1; prog_sel = 4'd1;
        pc_q.push_back(exp_pc(1));
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("midrst_core_run", 32'(core_run), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pc_load", 32'(pc_load), 32'd0);
        check("midrst_cycle_count", 32'(cycle_count), 32'd0);
        check("midrst_run_count", 32'(run_count), 32'd0);
        model_runs = 0;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        run_txn(2, 6, 99, 0);
        run_txn(5, 99, 99, 0);

        repeat (4) @(posedge clk);
        check("pc_q_drained", 32'(pc_q.size()), 32'd0);
        check("res_q_drained", 32'(res_q.size()), 32'd0);
        check("len_q_drained", 32'(len_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
